// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter that shares one fixed-latency pipelined multiplier
// between NUM_REQ requesters and routes each product back to the requester
// that issued it.
module multiplier_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned INPUT_DATA_WIDTH  = 32,
    parameter int unsigned OUTPUT_DATA_WIDTH = 64,
    parameter int unsigned MULT_LATENCY      = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  arb_en,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0]   req_in1,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0]   req_in2,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [OUTPUT_DATA_WIDTH-1:0]          resp_out,
    output logic [INPUT_DATA_WIDTH-1:0]           mult_in1,
    output logic [INPUT_DATA_WIDTH-1:0]           mult_in2,
    output logic                                  mult_inputs_valid,
    input  logic [OUTPUT_DATA_WIDTH-1:0]          mult_out,
    input  logic                                  mult_output_valid,
    output logic                                  busy,
    output logic                                  tag_err
);

    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Tag carried alongside each multiplier operation
    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] idx;
    } tag_t;

    logic [IDXW-1:0]              r_last_grant;
    logic [IDXW-1:0]              r_issue_idx;
    logic [INPUT_DATA_WIDTH-1:0]  r_mult_in1;
    logic [INPUT_DATA_WIDTH-1:0]  r_mult_in2;
    logic                         r_mult_valid;
    tag_t                         r_tag [MULT_LATENCY];
    logic [NUM_REQ-1:0]           r_resp_valid;
    logic [OUTPUT_DATA_WIDTH-1:0] r_resp_out;
    logic                         r_tag_err;

    logic [NUM_REQ-1:0]           w_ready;
    logic [IDXW-1:0]              w_grant_idx;
    logic                         w_found;
    logic                         w_hs;
    logic [INPUT_DATA_WIDTH-1:0]  w_sel_in1;
    logic [INPUT_DATA_WIDTH-1:0]  w_sel_in2;
    tag_t                         w_tag_out;
    logic                         w_any_tag;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_ready     = '0;
        w_grant_idx = r_last_grant;
        w_found     = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            logic [IDXW-1:0] cand;
            cand = IDXW'((32'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[cand]) begin
                w_found     = 1'b1;
                w_grant_idx = cand;
            end
        end
        if (w_found && arb_en && !reset) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_hs      = |(req_valid & w_ready);
    assign req_ready = w_ready;

    // Operand mux for the granted requester
    always_comb begin
        w_sel_in1 = '0;
        w_sel_in2 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDXW'(i) == w_grant_idx) begin
                w_sel_in1 = req_in1[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                w_sel_in2 = req_in2[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
            end
        end
    end

    // Issue stage: register operands and grant pointer on a handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mult_in1   <= '0;
            r_mult_in2   <= '0;
            r_mult_valid <= 1'b0;
            r_issue_idx  <= '0;
            r_last_grant <= IDXW'(NUM_REQ - 1);
        end else begin
            r_mult_valid <= w_hs;
            if (w_hs) begin
                r_mult_in1   <= w_sel_in1;
                r_mult_in2   <= w_sel_in2;
                r_issue_idx  <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
        end
    end

    // Tag pipeline tracks which requester owns each multiplier stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MULT_LATENCY); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= {r_mult_valid, r_issue_idx};
            for (int i = 1; i < int'(MULT_LATENCY); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tag_out = r_tag[MULT_LATENCY-1];

    // Any tag stage still holding a live operation
    always_comb begin
        w_any_tag = 1'b0;
        for (int i = 0; i < int'(MULT_LATENCY); i++) begin
            w_any_tag = w_any_tag | r_tag[i].vld;
        end
    end

    // Result capture and routing; the tag, not the multiplier, decides delivery
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= '0;
            r_resp_out   <= '0;
            r_tag_err    <= 1'b0;
        end else begin
            r_resp_valid <= w_tag_out.vld ? (NUM_REQ'(1) << w_tag_out.idx) : '0;
            if (w_tag_out.vld) begin
                r_resp_out <= mult_out;
            end
            if (mult_output_valid != w_tag_out.vld) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign mult_in1          = r_mult_in1;
    assign mult_in2          = r_mult_in2;
    assign mult_inputs_valid = r_mult_valid;
    assign resp_valid        = r_resp_valid;
    assign resp_out          = r_resp_out;
    assign tag_err           = r_tag_err;
    assign busy              = r_mult_valid | w_any_tag | (|r_resp_valid);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter with a behavioural 3-stage multiplier
// and a scoreboard of expected responses keyed by delivery cycle.
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int OW = 64;
    localparam int L  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              arb_en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_in1;
    logic [N*W-1:0]    req_in2;
    logic [N-1:0]      resp_valid;
    logic [OW-1:0]     resp_out;
    logic [W-1:0]      mult_in1;
    logic [W-1:0]      mult_in2;
    logic              mult_inputs_valid;
    logic [OW-1:0]     mult_out;
    logic              mult_output_valid;
    logic              busy;
    logic              tag_err;
    logic              early;

    multiplier_arbiter #(
        .NUM_REQ(N), .INPUT_DATA_WIDTH(W), .OUTPUT_DATA_WIDTH(OW), .MULT_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .resp_valid(resp_valid), .resp_out(resp_out),
        .mult_in1(mult_in1), .mult_in2(mult_in2),
        .mult_inputs_valid(mult_inputs_valid),
        .mult_out(mult_out), .mult_output_valid(mult_output_valid),
        .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier; 'early' raises output_valid one cycle too soon
    logic [L-1:0] st_v;
    logic [OW-1:0] st_p [L];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st_v <= '0;
            for (int i = 0; i < L; i++) st_p[i] <= '0;
        end else begin
            st_v    <= {st_v[L-2:0], mult_inputs_valid};
            st_p[0] <= 64'(mult_in1) * 64'(mult_in2);
            for (int i = 1; i < L; i++) st_p[i] <= st_p[i-1];
        end
    end
    assign mult_output_valid = early ? st_v[L-2] : st_v[L-1];
    assign mult_out          = st_p[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        logic [N-1:0]  oh;
        logic [OW-1:0] prod;
        int            due;
    } sb_t;
    sb_t sb[$];

    // Response monitor: every strobe must match the head of the scoreboard on its due cycle
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("resp_valid", 64'(resp_valid), 64'(sb[0].oh));
            chk("resp_out", resp_out, sb[0].prod);
            sb.delete(0);
        end else if (resp_valid != '0) begin
            chk("spurious_resp", 64'(resp_valid), 64'd0);
        end
    end

    logic [W-1:0] cur_a, cur_b;

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        cur_a = a;
        cur_b = b;
        for (int i = 0; i < N; i++) begin
            req_in1[i*W +: W] = a + W'(i);
            req_in2[i*W +: W] = b + W'(2*i);
        end
    endtask

    function automatic logic [OW-1:0] prod_of(input logic [N-1:0] oh,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        int idx = 0;
        for (int i = 0; i < N; i++) if (oh[i]) idx = i;
        return 64'(a + W'(idx)) * 64'(b + W'(2*idx));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one request pattern at a negedge, check the grant, log any expected result
    task automatic issue(input logic [N-1:0] v, input logic en, input logic [N-1:0] exp,
                         input string nm);
        sb_t e;
        req_valid = v;
        arb_en    = en;
        #1;
        chk(nm, 64'(req_ready), 64'(exp));
        if (exp != '0) begin
            e.oh   = exp;
            e.prod = prod_of(exp, cur_a, cur_b);
            e.due  = cyc + L + 2;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input string nm);
        reset     = 1'b1;
        early     = 1'b0;
        req_valid = '1;
        arb_en    = 1'b1;
        sb.delete();
        #1;
        chk({nm, "_ready"}, 64'(req_ready), 64'd0);
        chk({nm, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({nm, "_resp_out"}, resp_out, 64'd0);
        chk({nm, "_mult_valid"}, 64'(mult_inputs_valid), 64'd0);
        chk({nm, "_mult_in1"}, 64'(mult_in1), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_tag_err"}, 64'(tag_err), 64'd0);
        next_cycle();
        req_valid = '0;
        reset     = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         en;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] prev_exp;
        logic [W-1:0] exp_in1, exp_in2;
        logic [N-1:0] oh;

        tbl[0]  = '{4'b0010, 1'b1, 32'd5,          32'd3,          4'b0010};
        tbl[1]  = '{4'b1010, 1'b1, 32'd2,          32'd11,         4'b1000};
        tbl[2]  = '{4'b1010, 1'b1, 32'd9,          32'd9,          4'b0010};
        tbl[3]  = '{4'b1010, 1'b1, 32'd100,        32'd7,          4'b1000};
        tbl[4]  = '{4'b0000, 1'b1, 32'd1,          32'd1,          4'b0000};
        tbl[5]  = '{4'b1111, 1'b0, 32'd4,          32'd4,          4'b0000};
        tbl[6]  = '{4'b1111, 1'b1, 32'd12,         32'd13,         4'b0001};
        tbl[7]  = '{4'b0001, 1'b1, 32'hFFFF_FFF0,  32'hFFFF_FFF0,  4'b0001};
        tbl[8]  = '{4'b1001, 1'b1, 32'd1000,       32'd3,          4'b1000};
        tbl[9]  = '{4'b0110, 1'b1, 32'd17,         32'd19,         4'b0010};
        tbl[10] = '{4'b0101, 1'b1, 32'd21,         32'd23,         4'b0100};
        tbl[11] = '{4'b0011, 1'b1, 32'd0,          32'd55,         4'b0001};

        reset     = 1'b1;
        early     = 1'b0;
        arb_en    = 1'b0;
        req_valid = '0;
        set_ops(32'd0, 32'd0);
        @(negedge clk);
        do_reset("init");

        // Table: arbitration, operand registration and hold behaviour
        prev_exp = '0;
        exp_in1  = '0;
        exp_in2  = '0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("tbl%0d_mult_valid", k), 64'(mult_inputs_valid), 64'(prev_exp != '0));
            chk($sformatf("tbl%0d_mult_in1", k), 64'(mult_in1), 64'(exp_in1));
            chk($sformatf("tbl%0d_mult_in2", k), 64'(mult_in2), 64'(exp_in2));
            set_ops(tbl[k].a, tbl[k].b);
            issue(tbl[k].v, tbl[k].en, tbl[k].exp, $sformatf("tbl%0d_ready", k));
            if (tbl[k].exp != '0) begin
                for (int i = 0; i < N; i++) if (tbl[k].exp[i]) begin
                    exp_in1 = tbl[k].a + W'(i);
                    exp_in2 = tbl[k].b + W'(2*i);
                end
            end
            prev_exp = tbl[k].exp;
            next_cycle();
        end
        req_valid = '0;
        repeat (8) next_cycle();
        chk("tbl_idle_busy", 64'(busy), 64'd0);

        // Single requester 1, 7*9
        set_ops(32'd6, 32'd7);
        issue(4'b0010, 1'b1, 4'b0010, "single_ready");
        next_cycle();
        req_valid = '0;
        chk("single_mult_valid", 64'(mult_inputs_valid), 64'd1);
        chk("single_mult_in1", 64'(mult_in1), 64'd7);
        chk("single_mult_in2", 64'(mult_in2), 64'd9);
        chk("single_busy_t1", 64'(busy), 64'd1);
        next_cycle();
        chk("single_mult_valid_t2", 64'(mult_inputs_valid), 64'd0);
        chk("single_mult_in1_hold", 64'(mult_in1), 64'd7);
        repeat (3) next_cycle();
        chk("single_resp_valid_t5", 64'(resp_valid), 64'b0010);
        chk("single_resp_out_t5", resp_out, 64'd63);
        next_cycle();
        chk("single_resp_valid_t6", 64'(resp_valid), 64'd0);
        chk("single_resp_out_hold", resp_out, 64'd63);
        chk("single_busy_t6", 64'(busy), 64'd0);

        // All four requesters valid for 8 cycles straight from reset
        do_reset("rst_all");
        set_ops(32'd20, 32'd30);
        for (int k = 0; k < 8; k++) begin
            oh = 4'b0001 << (k % 4);
            issue(4'b1111, 1'b1, oh, $sformatf("all_grant%0d", k));
            next_cycle();
        end
        req_valid = '0;
        repeat (4) next_cycle();
        chk("all_busy_t5", 64'(busy), 64'd1);
        next_cycle();
        chk("all_busy_t6", 64'(busy), 64'd0);

        // arb_en drops after two grants
        do_reset("rst_en");
        set_ops(32'd3, 32'd5);
        issue(4'b1111, 1'b1, 4'b0001, "en_grant0");
        next_cycle();
        issue(4'b1111, 1'b1, 4'b0010, "en_grant1");
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            issue(4'b1111, 1'b0, 4'b0000, $sformatf("en_off%0d", k));
            next_cycle();
        end
        req_valid = '0;
        arb_en    = 1'b1;
        repeat (4) next_cycle();
        chk("en_busy_drained", 64'(busy), 64'd0);

        // Multiplier output_valid one cycle early
        do_reset("rst_err");
        early = 1'b1;
        set_ops(32'd2, 32'd2);
        issue(4'b0001, 1'b1, 4'b0001, "err_grant");
        next_cycle();
        req_valid = '0;
        chk("err_tag_err_t1", 64'(tag_err), 64'd0);
        repeat (5) next_cycle();
        chk("err_tag_err_set", 64'(tag_err), 64'd1);
        repeat (5) next_cycle();
        chk("err_tag_err_held", 64'(tag_err), 64'd1);
        do_reset("err_clear");

        // Reset two cycles after a grant discards the operation
        set_ops(32'd4, 32'd6);
        issue(4'b1111, 1'b1, 4'b0001, "rst24_grant0");
        next_cycle();
        req_valid = '0;
        repeat (5) next_cycle();
        chk("rst24_resp_out", resp_out, 64'd24);
        issue(4'b0100, 1'b1, 4'b0100, "rst24_grant2");
        next_cycle();
        req_valid = '0;
        next_cycle();
        do_reset("rst24");
        repeat (8) next_cycle();
        chk("rst24_busy_idle", 64'(busy), 64'd0);
        issue(4'b1111, 1'b1, 4'b0001, "rst24_first_grant");
        next_cycle();
        req_valid = '0;
        repeat (8) next_cycle();
        chk("final_sb_drained", 64'(sb.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
